// File: rtl/seq_mulx.sv
// Sequential shift-add multiplier, one multiplier bit per clock, signed/unsigned per operation.
// Optional SEQ_MULX_EARLY_EXIT_EN ends CALC once the remaining multiplier magnitude is zero.
module seq_mulx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic {IDLE, CALC} state_t;

  state_t            r_state;
  logic [PW-1:0]     r_mcand;
  logic [WIDTH-1:0]  r_mplier;
  logic [PW-1:0]     r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg;
  logic              r_busy;
  logic              r_done;
  logic [PW-1:0]     r_p;

  logic [WIDTH-1:0]  w_a_mag;
  logic [WIDTH-1:0]  w_b_mag;
  logic              w_neg;
  logic [PW-1:0]     w_acc_sum;
  logic [WIDTH-1:0]  w_mplier_sh;
  logic              w_last;
  logic [PW-1:0]     w_result;

  // Magnitude of the most-negative value wraps to itself, which is the correct unsigned magnitude.
  assign w_a_mag     = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign w_b_mag     = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign w_neg       = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign w_acc_sum   = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mplier_sh = r_mplier >> 1;
  assign w_result    = r_neg ? (~w_acc_sum + PW'(1)) : w_acc_sum;

`ifdef SEQ_MULX_EARLY_EXIT_EN
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || (w_mplier_sh == '0);
`else
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_p      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_neg    <= w_neg;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_acc    <= w_acc_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_sh;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_p     <= w_result;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign p    = r_p;

endmodule

// File: tb/tb_seq_mulx.sv
// Directed and random checks of seq_mulx at WIDTH=8 and WIDTH=16.
module tb_seq_mulx;

  logic        clk;
  logic        rst_n;

  logic        start8, s8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        start16, s16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_MULX_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  seq_mulx #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(s8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
  );

  seq_mulx #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .is_signed(s16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .p(p16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected latency: early-exit value when the feature is built in, otherwise the full 8 cycles.
  function automatic int lat8(input int ee_lat);
    return EE ? ee_lat : 8;
  endfunction

  function automatic int lat_model(input logic [15:0] b, input logic s, input int w);
    logic [15:0] mag;
    int h;
    if (!EE) return w;
    mag = (s && b[w-1]) ? (16'(~b) + 16'd1) : b;
    if (w < 16) mag = mag & ((16'd1 << w) - 16'd1);
    h = 0;
    for (int i = 0; i < w; i++) if (mag[i]) h = i + 1;
    return (h == 0) ? 1 : h;
  endfunction

  function automatic logic [63:0] ref_prod(input logic [15:0] a, input logic [15:0] b,
                                            input logic s, input int w);
    longint x, y;
    logic [63:0] r;
    if (w == 8) begin
      x = s ? longint'($signed(a[7:0])) : longint'(a[7:0]);
      y = s ? longint'($signed(b[7:0])) : longint'(b[7:0]);
      r = 64'(x * y);
      return r & 64'hFFFF;
    end
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    r = 64'(x * y);
    return r & 64'hFFFF_FFFF;
  endfunction

  task automatic run8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                      input logic is, input logic [15:0] ep, input int elat);
    int lat, bcnt;
    @(negedge clk);
    a8 = ia; b8 = ib; s8 = is; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0; bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_done"}, 64'(done8), 64'd1);
    chk({tag, "_p"}, 64'(p8), 64'(ep));
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_busycyc"}, 64'(bcnt), 64'(elat));
    chk({tag, "_busy_at_done"}, 64'(busy8), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(done8), 64'd0);
  endtask

  task automatic run16(input logic [15:0] ia, input logic [15:0] ib, input logic is);
    int lat;
    @(negedge clk);
    a16 = ia; b16 = ib; s16 = is; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rnd16_done", 64'(done16), 64'd1);
    chk("rnd16_p", 64'(p16), ref_prod(ia, ib, is, 16));
    chk("rnd16_lat", 64'(lat), 64'(lat_model(ib, is, 16)));
  endtask

  initial begin
    int lat, dcnt;
    logic [7:0]  ra, rb;
    logic [15:0] ra16, rb16;
    logic        rs;

    rst_n = 1'b0;
    start8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; s16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_p", 64'(p8), 64'd0);
    chk("rst_p16", 64'(p16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run8("uns_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01, lat8(8));
    run8("sgn_80_7f", 8'h80, 8'h7F, 1'b1, 16'hC080, lat8(7));
    run8("sgn_80_80", 8'h80, 8'h80, 1'b1, 16'h4000, lat8(8));
    run8("sgn_fd_05", 8'hFD, 8'h05, 1'b1, 16'hFFF1, lat8(3));
    run8("sgn_05_fd", 8'h05, 8'hFD, 1'b1, 16'hFFF1, lat8(2));
    run8("uns_fd_05", 8'hFD, 8'h05, 1'b0, 16'h04F1, lat8(3));
    run8("zero_b", 8'h12, 8'h00, 1'b0, 16'h0000, lat8(1));
    run8("a7_b5", 8'h07, 8'h05, 1'b0, 16'd35, lat8(3));

    // Start held high through busy with changing operands, then reused in the done cycle.
    @(negedge clk);
    a8 = 8'h0A; b8 = 8'h0B; s8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h55; b8 = 8'h66;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hs1_p", 64'(p8), 64'h006E);
    chk("hs1_lat", 64'(lat), 64'(lat8(4)));
    a8 = 8'd3; b8 = 8'd4;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("hs2_busy", 64'(busy8), 64'd1);
    chk("hs2_done_low", 64'(done8), 64'd0);
    lat = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hs2_p", 64'(p8), 64'd12);
    chk("hs2_lat", 64'(lat), 64'(lat8(3)));

    // Reset in the middle of an operation.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy8), 64'd0);
    chk("midrst_done", 64'(done8), 64'd0);
    chk("midrst_p", 64'(p8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) dcnt++;
    end
    chk("midrst_no_done", 64'(dcnt), 64'd0);
    chk("midrst_idle", 64'(busy8), 64'd0);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      run8("rnd8", ra, rb, rs, 16'(ref_prod({8'd0, ra}, {8'd0, rb}, rs, 8)),
           lat_model({8'd0, rb}, rs, 8));
    end

    for (int i = 0; i < 1000; i++) begin
      ra16 = 16'($urandom);
      rb16 = 16'($urandom);
      rs   = 1'($urandom);
      run16(ra16, rb16, rs);
    end
    run16(16'h8000, 16'h8000, 1'b1);
    run16(16'hFFFF, 16'hFFFF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mulx.md
Name: seq_mulx

Overview:
- Parametrised sequential shift-add multiplier; multi-cycle successor to the combinational unsigned multiplier.
- Adds operand width parameter, signed/unsigned mode per operation, start/busy/done handshake, registered product.
- Sits beside the ALU as a slow-path MUL unit.
- Retires one multiplier bit per clock: small area, deterministic latency.

Parameters:
- WIDTH, 8, operand width in bits (>= 2); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled on clk rise when not busy.
- is_signed  in  1  sampled with start; 1 = two's-complement operands, 0 = unsigned.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when p is updated.
- p  out  2*WIDTH  product; holds the last result until the next done.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, p=0; internal accumulator, operand registers and counter cleared. Reset mid-operation aborts it; no done is produced.
- States: IDLE, CALC.
- IDLE: start=1 at edge k latches a, b, is_signed. Next state CALC, busy=1, counter=0, accumulator=0. Magnitudes are taken if is_signed and the operand MSB=1. Result sign = a_msb XOR b_msb when signed, else 0.
- CALC, each cycle:
  - If the multiplier LSB is 1, add the multiplicand to the accumulator (2*WIDTH bits, no overflow possible).
  - Shift the multiplicand left 1 and the multiplier right 1; counter+1.
  - After WIDTH iterations, at edge k+WIDTH: p = sign ? -acc : acc (2*WIDTH-bit two's complement); done=1; busy=0; state IDLE.
- Latency: start accepted at edge k -> done high and p valid after edge k+WIDTH. busy is high after edges k..k+WIDTH-1.
- done is high exactly one cycle. start while busy is ignored; no queuing. start during the done cycle is accepted (state is IDLE), allowing back-to-back operations every WIDTH cycles.
- Operands changing while busy have no effect.
- Signed corner: most-negative x most-negative is exact (WIDTH=8: -128 x -128 = 16384 = 16'h4000).
- A zero operand still takes the full latency (unless the optional feature is enabled).

Optional Feature:
- Macro SEQ_MULX_EARLY_EXIT_EN.
- Defined: CALC also terminates at the end of any cycle in which the shifted multiplier magnitude becomes zero. Latency = max(1, index of highest set bit of |b| + 1) cycles. Examples: b=0 -> 1 cycle; b=5 -> 3 cycles.
- The done, p and busy timing rules are otherwise unchanged.
- Undefined: fixed WIDTH-cycle latency.

Test Plan:
- Reset: assert rst_n=0 mid-CALC -> busy=0, done=0, p=0 immediately. After release, no done pulse appears.
- Unsigned, WIDTH=8: a=8'hFF, b=8'hFF, is_signed=0 -> done 8 cycles after start, p=16'hFE01. busy high exactly 8 cycles.
- Signed: a=8'h80 (-128), b=8'h7F (127), is_signed=1 -> p=16'hC080 (-16256). Then a=8'h80, b=8'h80 -> p=16'h4000.
- Handshake: start held high during busy with new operands -> ignored. Start asserted in the done cycle with a=3, b=4 -> second done exactly 8 cycles later, p=16'd12.
- Early exit (macro defined): b=0 -> done 1 cycle after start, p=0. b=5, a=7 -> done after 3 cycles, p=35. Macro undefined: same stimuli take 8 cycles.
- Random regression: 1000 random a, b, is_signed at WIDTH=8 and WIDTH=16 -> p matches the reference product in every case.
